ro_puf_comparator: RTL and testbench
====================================

Name: ro_puf_comparator

Overview:
- Arbiter/comparator stage of the ring-oscillator PUF.
- Takes the two 4-bit race counters (count2 from the out2 oscillator group, count1 from the out1 group), which run in their oscillator clock domains.
- Synchronises both counters into clk, detects the end of the race (either counter saturated), and registers the PUF response bit plus the magnitude of the count difference.

Parameters:
- WIDTH, 4, counter width; the saturation value is 2^WIDTH-1.
- SYNC_STAGES, 2, flip-flop synchroniser depth per input bit (minimum 2).
- STABLE_CYCLES, 2, consecutive equal synchronised samples required before a counter value is accepted (minimum 1).

Ports:
- clk  in  1  system clock; all outputs are registered on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- count2  in  WIDTH  race counter of oscillator group 2; asynchronous to clk.
- count1  in  WIDTH  race counter of oscillator group 1; asynchronous to clk.
- clear  in  1  synchronous pulse; drops valid and the result outputs for a new challenge.
- count  out  WIDTH  |count2 - count1| captured at race end.
- resp  out  1  PUF response bit; 1 when count2 > count1 at race end.
- tie  out  1  1 when count2 == count1 at race end.
- valid  out  1  result outputs hold a captured race result.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Synchroniser and filter state cleared; accepted values a2=a1=0.
  - count=0, resp=0, tie=0, valid=0, armed=1.
  - Removal of reset is used synchronously.
- Input path:
  - Each input bit goes through SYNC_STAGES flops.
  - The filter loads a2/a1 only when the synchronised vector has been identical for STABLE_CYCLES consecutive clk edges. This rejects torn multi-bit samples from the binary counters.
- Done condition: done = (a2 == MAX) or (a1 == MAX), with MAX = 2^WIDTH-1 (15 for the default width). This matches upstream counter saturation.
- Capture: on a clk edge with done=1, armed=1 and clear=0:
  - count <= (a2 >= a1) ? a2-a1 : a1-a2, in unsigned WIDTH-bit arithmetic with no wrap.
  - resp <= (a2 > a1).
  - tie <= (a2 == a1).
  - valid <= 1, armed <= 0.
- Hold: result outputs and valid stay stable while valid=1, regardless of input changes.
- Clear (clear=1):
  - Next edge: valid=0, count=0, resp=0, tie=0.
  - Clear has priority over a same-cycle capture.
- Upstream counter reset (a2==0 and a1==0 accepted): valid=0 and outputs zeroed exactly as for clear.
- Re-arm: armed <= 1 on any edge where done=0. A saturated pair therefore cannot re-capture after clear until the counters have left saturation.
- Both saturated (a2=a1=MAX): count=0, resp=0, tie=1.
- Latency from a stable input change to valid: SYNC_STAGES + STABLE_CYCLES + 1 clk edges (5 for the defaults).
- Reset asserted mid-race: all state is abandoned immediately and armed=1.

Decomposition:
- Shared package ro_puf_pkg holds the WIDTH default, the MAX_COUNT constant derived from it, and the capture-priority encoding (reset > clear > capture > hold).
- One natural sub-module: cnt_sync_filter (SYNC_STAGES synchroniser + STABLE_CYCLES stability filter). It is instantiated twice, once per counter.
- The top level contains the done/armed logic, the subtractor and the result registers.

Test Plan:
- Reset mid-operation: drive count2=15, count1=9 and wait for valid=1, then pulse reset_n low. Required: all outputs 0 immediately (asynchronously), and valid=1 again after reset_n rises, SYNC_STAGES+STABLE_CYCLES+1 edges later.
- Normal race: count2=15, count1=9 held steady. Required: valid=1 exactly 5 clk edges later with count=6, resp=1, tie=0.
- Reverse race and tie:
  - count2=3, count1=15 gives count=12, resp=0, tie=0.
  - count2=15, count1=15 gives count=0, resp=0, tie=1.
- Glitch rejection: count2 toggles 7->8->7 on consecutive clk cycles, then settles at 15 while count1=4. Required: no capture from the transient values, and the final capture is count=11, resp=1.
- Clear/re-arm:
  - After a capture with inputs still 15/9, pulse clear. Required: valid=0 and no re-capture.
  - Then drive both counts to 0, followed by count2=2, count1=15. Required: a new capture with count=13, resp=0.
- Hold: with valid=1 (15/9), change the inputs to 0/5. Required: outputs unchanged.

Source files
------------

// File: rtl/ro_puf_comparator_pkg.sv
// Shared constants and types for the RO-PUF comparator stage.
// Holds default width, saturation value and capture-priority encoding.
package ro_puf_pkg;

  localparam int PUF_WIDTH = 4;

  localparam logic [PUF_WIDTH-1:0] MAX_COUNT =
    PUF_WIDTH'((1 << PUF_WIDTH) - 1);

  // Result-register action, highest priority first:
  // reset > clear > capture > hold.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_CAPTURE = 2'd1,
    ACT_CLEAR   = 2'd2,
    ACT_RESET   = 2'd3
  } act_e;

endpackage

// File: rtl/ro_puf_comparator_if.sv
// Bundle between the race counters / controller and the comparator.
// master drives counters and clear; slave returns the race result.
interface ro_puf_comparator_if
  import ro_puf_pkg::*;
#(
  parameter int WIDTH = PUF_WIDTH
);

  logic [WIDTH-1:0] count2;
  logic [WIDTH-1:0] count1;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             resp;
  logic             tie;
  logic             valid;

  modport master (
    output count2, count1, clear,
    input  count, resp, tie, valid
  );

  modport slave (
    input  count2, count1, clear,
    output count, resp, tie, valid
  );

endinterface

// File: rtl/ro_puf_comparator_cnt_sync_filter.sv
// Multi-flop synchroniser plus stability filter for one race counter.
// A value is accepted only after it has been sampled unchanged long enough.
module cnt_sync_filter #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_cnt,
  output logic [WIDTH-1:0] o_cnt
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_acc;
  logic [RW-1:0]    r_run;
  logic [RW-1:0]    w_run_nxt;
  logic [WIDTH-1:0] w_s;

  assign w_s   = r_sync[SYNC_STAGES-1];
  assign o_cnt = r_acc;

  // Run length of identical synchronised samples, saturating.
  always_comb begin
    w_run_nxt = RW'(1);
    if (w_s == r_prev) begin
      w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX
                                     : r_run + RW'(1);
    end
  end

  // Synchroniser chain into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_cnt;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Stability filter: load once the run reaches the required length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
      r_run  <= '0;
      r_acc  <= '0;
    end else begin
      r_prev <= w_s;
      r_run  <= w_run_nxt;
      if (w_run_nxt == RUN_MAX) r_acc <= w_s;
    end
  end

endmodule

// File: rtl/ro_puf_comparator.sv
// RO-PUF arbiter: syncs both race counters, detects saturation and
// registers the response bit, tie flag and count difference.
module ro_puf_comparator
  import ro_puf_pkg::*;
#(
  parameter int WIDTH         = PUF_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input logic               clk,
  input logic               reset_n,
  ro_puf_comparator_if.slave bus
);

  localparam logic [WIDTH-1:0] W_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] w_a2;
  logic [WIDTH-1:0] w_a1;
  logic             w_done;
  logic             w_zero;
  logic             w_clr;
  logic             w_cap;
  logic [WIDTH-1:0] w_diff;
  act_e             w_act;

  logic [WIDTH-1:0] r_count;
  logic             r_resp;
  logic             r_tie;
  logic             r_valid;
  logic             r_armed;

  cnt_sync_filter #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_f2 (
    .clk    (clk),
    .reset_n(reset_n),
    .i_cnt  (bus.count2),
    .o_cnt  (w_a2)
  );

  cnt_sync_filter #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_f1 (
    .clk    (clk),
    .reset_n(reset_n),
    .i_cnt  (bus.count1),
    .o_cnt  (w_a1)
  );

  // Race-end detection and result-register action selection.
  always_comb begin
    w_done = (w_a2 == W_MAX) || (w_a1 == W_MAX);
    w_zero = (w_a2 == '0) && (w_a1 == '0);
    w_clr  = bus.clear || w_zero;
    w_cap  = w_done && r_armed && !r_valid && !w_clr;
    w_diff = (w_a2 >= w_a1) ? (w_a2 - w_a1) : (w_a1 - w_a2);
    w_act  = ACT_HOLD;
    unique case (1'b1)
      w_clr:   w_act = ACT_CLEAR;
      w_cap:   w_act = ACT_CAPTURE;
      default: w_act = ACT_HOLD;
    endcase
  end

  // Result registers: clear beats capture, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_resp  <= 1'b0;
      r_tie   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (w_act)
        ACT_CLEAR: begin
          r_count <= '0;
          r_resp  <= 1'b0;
          r_tie   <= 1'b0;
          r_valid <= 1'b0;
        end
        ACT_CAPTURE: begin
          r_count <= w_diff;
          r_resp  <= (w_a2 > w_a1);
          r_tie   <= (w_a2 == w_a1);
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Armed drops on capture and returns once the counters leave saturation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed <= 1'b1;
    end else if (!w_done) begin
      r_armed <= 1'b1;
    end else if (w_act == ACT_CAPTURE) begin
      r_armed <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.resp  = r_resp;
  assign bus.tie   = r_tie;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_ro_puf_comparator.sv
// Directed bench for the RO-PUF comparator.
// Hand-computed expectations checked with immediate assertions.
module tb_ro_puf_comparator;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  ro_puf_comparator_if #(.WIDTH(4)) bus();

  ro_puf_comparator #(
    .WIDTH        (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] c2, input logic [3:0] c1);
    @(negedge clk);
    bus.count2 = c2;
    bus.count1 = c1;
  endtask

  // Count edges until valid rises, bounded at 20.
  task automatic wait_valid(input string tag, input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk(tag, n, exp_edges);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] c,
                         input logic r,
                         input logic t,
                         input logic v);
    chk({tag, "_count"}, 32'(bus.count), 32'(c));
    chk({tag, "_resp"},  32'(bus.resp),  32'(r));
    chk({tag, "_tie"},   32'(bus.tie),   32'(t));
    chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    bus.count2 = 4'd0;
    bus.count1 = 4'd0;
    bus.clear  = 1'b0;
    idle(3);
    chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);

    // Normal race 15/9
    drive(4'd15, 4'd9);
    wait_valid("normal_lat", 5);
    chk_out("normal", 4'd6, 1'b1, 1'b0, 1'b1);

    // Hold while valid
    drive(4'd0, 4'd5);
    idle(8);
    chk_out("hold", 4'd6, 1'b1, 1'b0, 1'b1);

    // Reverse race 3/15
    pulse_clear();
    chk_out("clr1", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd3, 4'd15);
    wait_valid("rev_lat", 5);
    chk_out("rev", 4'd12, 1'b0, 1'b0, 1'b1);

    // Tie 15/15 after leaving saturation
    pulse_clear();
    idle(6);
    chk("rev_norecap", 32'(bus.valid), 32'd0);
    drive(4'd0, 4'd0);
    idle(6);
    drive(4'd15, 4'd15);
    wait_valid("tie_lat", 5);
    chk_out("tie", 4'd0, 1'b0, 1'b1, 1'b1);

    // Clear with saturated inputs, then re-arm
    drive(4'd0, 4'd0);
    idle(6);
    chk_out("zero", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd15, 4'd9);
    wait_valid("cap2_lat", 5);
    pulse_clear();
    idle(8);
    chk_out("clr_norecap", 4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 4'd0);
    idle(6);
    drive(4'd2, 4'd15);
    wait_valid("rearm_lat", 5);
    chk_out("rearm", 4'd13, 1'b0, 1'b0, 1'b1);

    // Glitch rejection on count2
    drive(4'd0, 4'd0);
    idle(6);
    drive(4'd7, 4'd4);
    drive(4'd8, 4'd4);
    drive(4'd7, 4'd4);
    drive(4'd15, 4'd4);
    wait_valid("glitch_lat", 5);
    chk_out("glitch", 4'd11, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation
    drive(4'd0, 4'd0);
    idle(6);
    drive(4'd15, 4'd9);
    wait_valid("pre_rst_lat", 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    wait_valid("post_rst_lat", 5);
    chk_out("post_rst", 4'd6, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
